alu_mdu_seq: RTL
================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised-width execute unit. Base RV32I integer ops plus an iterative multiply/divide
//  (M-subset) sequencer, behind a valid/ready handshake on both sides.
//  Sits in EX between the decode/regfile operand latch and the writeback mux.
//  Base ops take 1 cycle; MUL*/DIV*/REM* take XLEN+1 cycles.
// PARAMETERS
//  XLEN   32  operand/result width; power of 2, >= 8; shift amount = inputB[$clog2(XLEN)-1:0]
//  TAG_W  5   width of passthrough tag (destination register index)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request present
//  in_ready   out  1      unit can accept; 1 only in IDLE
//  op         in   4      0 ADD,1 SUB,2 SLL,3 SRL,4 SRA,5 AND,6 OR,7 XOR,8 SLT,9 SLTU,
//                         10 MUL,11 MULHU,12 DIV,13 DIVU,14 REM,15 REMU
//  inputA     in   XLEN   operand A (signed for SRA/SLT/DIV/REM)
//  inputB     in   XLEN   operand B
//  tag_in     in   TAG_W  captured on accept
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  ALUResult  out  XLEN   result
//  tag_out    out  TAG_W  tag captured with this request
//  zero       out  1      ALUResult == 0 (all ops)
//  negative   out  1      ALUResult[XLEN-1]
//  illegal    out  1      op not supported in this build (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; out_valid, ALUResult, tag_out, zero, negative, illegal, counter = 0.
//  Reset wins over every other event; an in-flight MUL/DIV is discarded with no output.
//  Accept = in_valid & in_ready at edge T; operands, op and tag are latched.
//  FSM: IDLE -(accept, base op)-> DONE; IDLE -(MUL*)-> MUL; IDLE -(DIV*/REM*)-> DIV;
//       MUL/DIV -(counter == XLEN-1)-> DONE; DONE -(out_ready)-> IDLE.
//  Latency: base op out_valid at T+1. MUL*/DIV* out_valid at T+XLEN+1.
//  Base ops: ADD/SUB wrap modulo 2^XLEN. SLL/SRL/SRA use the low $clog2(XLEN) bits of B only.
//  SLT is signed; SLTU is unsigned; result is 1 or 0.
//  MUL: low XLEN bits of A*B. MULHU: high XLEN bits of unsigned 2*XLEN product.
//  Multiply is radix-2 shift-add, 1 bit per cycle.
//  DIV: restoring, 1 quotient bit per cycle. Signed ops divide magnitudes and fix sign at the end.
//  REM takes the sign of the dividend; quotient truncates toward zero.
//  Divide by zero: DIV/DIVU = all ones; REM/REMU = inputA. Still takes the full latency.
//  Signed overflow (A = -2^(XLEN-1), B = -1): DIV = A, REM = 0.
//  DONE holds ALUResult/tag_out/flags stable while out_valid & !out_ready (back-pressure).
//  in_ready = 0 in MUL, DIV and DONE. No accept in the same cycle as the DONE->IDLE handoff.
//  zero/negative/illegal are registered together with ALUResult and are valid only with out_valid.
// CONFIGURATION
//  ALU_DIV_EN defined: ops 12-15 are executed by the DIV sequencer; illegal is always 0.
//  ALU_DIV_EN undefined: no divider logic. Ops 12-15 are treated as base ops:
//    ALUResult = 0, illegal = 1, out_valid at T+1, tag passes through.
// TESTING
//  ADD 0x7FFFFFFF + 1 -> out_valid at T+1, ALUResult 0x80000000, negative 1, zero 0.
//  SRA 0x80000000 by B = 0x24 (only 4 used) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
//  MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE at T+33; in_ready low T+1..T+33.
//  DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF;
//    DIV 0x80000000 / -1 -> 0x80000000.
//  Hold out_ready = 0 for 5 cycles after DONE with tag 0x1A -> outputs stable;
//    the in_valid request waiting meanwhile is accepted only after IDLE is re-entered.
//  Assert rst at cycle 10 of a DIV -> next cycle out_valid 0, in_ready 1;
//    build without ALU_DIV_EN: DIV -> illegal 1, result 0 at T+1.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Execute unit: single-cycle RV32I ALU plus iterative MUL/DIV sequencer.
// Define ALU_DIV_EN to build the divider; otherwise ops 12-15 flag illegal.
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  inputA,
  input  logic [XLEN-1:0]  inputB,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ALUResult,
  output logic [TAG_W-1:0] tag_out,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, stateNext;
  logic [SW-1:0]   count;
  logic            accept, lastStep, mulOp, divOp, load;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] baseRes, result;
  logic            resIllegal;

  logic [2*XLEN-1:0] prod, prodNext;
  logic [XLEN-1:0]   mcand;
  logic [XLEN:0]     mulSum;
  logic              mulHigh;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign lastStep  = (count == SW'(XLEN-1));
  assign mulOp     = (op[3:1] == 3'b101);
  assign shamt     = inputB[SW-1:0];

`ifdef ALU_DIV_EN
  logic [XLEN-1:0] rem, quo, divisor, remNext, quoNext, divRes;
  logic [XLEN-1:0] absA, absB;
  logic [XLEN:0]   shifted, diff;
  logic            negQ, negR, wantRem, sgn;

  assign divOp   = (op[3:2] == 2'b11);
  assign sgn     = ~op[0];
  assign absA    = (sgn & inputA[XLEN-1]) ? -inputA : inputA;
  assign absB    = (sgn & inputB[XLEN-1]) ? -inputB : inputB;
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign remNext = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quoNext = {quo[XLEN-2:0], ~diff[XLEN]};
  // Magnitudes are divided; signs are restored on the final step
  assign divRes  = wantRem ? (negR ? -remNext : remNext)
                           : (negQ ? -quoNext : quoNext);
`else
  assign divOp = 1'b0;
`endif

  assign mulSum   = {1'b0, prod[2*XLEN-1:XLEN]}
                  + (prod[0] ? {1'b0, mcand} : '0);
  assign prodNext = {mulSum, prod[XLEN-1:1]};

  always_comb begin
    baseRes = '0;
    case (op)
      4'd0:    baseRes = inputA + inputB;
      4'd1:    baseRes = inputA - inputB;
      4'd2:    baseRes = inputA << shamt;
      4'd3:    baseRes = inputA >> shamt;
      4'd4:    baseRes = $signed(inputA) >>> shamt;
      4'd5:    baseRes = inputA & inputB;
      4'd6:    baseRes = inputA | inputB;
      4'd7:    baseRes = inputA ^ inputB;
      4'd8:    baseRes = XLEN'($signed(inputA) < $signed(inputB));
      4'd9:    baseRes = XLEN'(inputA < inputB);
      default: baseRes = '0;
    endcase
  end

  always_comb begin
    result = baseRes;
    if (state == MUL)
      result = mulHigh ? prodNext[2*XLEN-1:XLEN] : prodNext[XLEN-1:0];
`ifdef ALU_DIV_EN
    else if (state == DIV)
      result = divRes;
    resIllegal = 1'b0;
`else
    resIllegal = (op[3:2] == 2'b11);
`endif
  end

  assign load = (accept & ~mulOp & ~divOp)
              | ((state == MUL || state == DIV) & lastStep);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept)
                 stateNext = mulOp ? MUL : (divOp ? DIV : DONE);
      MUL,
      DIV:     if (lastStep) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      ALUResult <= '0;
      tag_out   <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept)
        count <= '0;
      else if (state == MUL || state == DIV)
        count <= count + SW'(1);
      if (accept)
        tag_out <= tag_in;
      if (load) begin
        ALUResult <= result;
        zero      <= (result == '0);
        negative  <= result[XLEN-1];
        illegal   <= (state == IDLE) & resIllegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prod    <= {{XLEN{1'b0}}, inputB};
      mcand   <= inputA;
      mulHigh <= op[0];
`ifdef ALU_DIV_EN
      quo     <= absA;
      rem     <= '0;
      divisor <= absB;
      wantRem <= op[1];
      negR    <= sgn & inputA[XLEN-1];
      negQ    <= sgn & (inputA[XLEN-1] ^ inputB[XLEN-1])
               & (inputB != '0);
`endif
    end else if (state == MUL) begin
      prod <= prodNext;
    end
`ifdef ALU_DIV_EN
    else if (state == DIV) begin
      rem <= remNext;
      quo <= quoNext;
    end
`endif
  end
endmodule
